// File: rtl/mem_arbiter_if.sv
// Memory request/response types and the bundle that connects mem_arbiter to
// its two requesters and to the backing memory port.
//   ireq_in  / ireq_out : instruction-side request / response
//   dreq_in  / dreq_out : data-side request / response
//   mem_in   / mem_out  : request to / response from backing memory
package mem_arbiter_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              mem_valid;
        logic              mem_instr;
        logic              mem_fence;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
        logic [STRB_W-1:0] mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic              mem_ready;
        logic [DATA_W-1:0] mem_rdata;
    } mem_out_type;
endpackage

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    mem_in_type  ireq_in;
    mem_out_type ireq_out;
    mem_in_type  dreq_in;
    mem_out_type dreq_out;
    mem_in_type  mem_in;
    mem_out_type mem_out;

    // arbiter side
    modport slave (
        input  ireq_in, dreq_in, mem_out,
        output ireq_out, dreq_out, mem_in
    );

    // requester/memory-model side
    modport master (
        output ireq_in, dreq_in, mem_out,
        input  ireq_out, dreq_out, mem_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between the instruction side
// and the data side. Round-robin arbitration, one-deep request slot per port,
// and burst locking so a port re-issuing on ready keeps the grant for up to
// burst_max beats while the other port waits.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave modport carrying ireq/dreq in/out and mem_in/mem_out
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned burst_max  = 4,
    parameter bit          prio_first = 1'b0
)(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W     = $clog2(burst_max) + 1;
    localparam logic [CNT_W-1:0] BEATS_MAX = CNT_W'(burst_max);
    localparam logic [CNT_W-1:0] BEATS_ONE = CNT_W'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_beats, w_beats_nxt;
    logic             r_rr, w_rr_nxt;       // last granted port: 0=instr, 1=data
    logic             r_full_i, r_full_d;
    mem_in_type       r_slot_i, r_slot_d;

    logic        w_busy_i, w_busy_d, w_done_i, w_done_d, w_done;
    logic        w_cap_i, w_cap_d, w_pend_i, w_pend_d;
    logic        w_own_d, w_refill, w_oth_pend, w_grant_d;
    mem_in_type  w_mem_in;
    mem_out_type w_iout, w_dout;

    assign w_busy_i = (r_state == BUSY_I);
    assign w_busy_d = (r_state == BUSY_D);
    assign w_done_i = bus.mem_out.mem_ready & w_busy_i;
    assign w_done_d = bus.mem_out.mem_ready & w_busy_d;
    assign w_done   = w_done_i | w_done_d;

    // A slot accepts a request when empty or when its current beat retires now
    assign w_cap_i  = bus.ireq_in.mem_valid & (~r_full_i | w_done_i);
    assign w_cap_d  = bus.dreq_in.mem_valid & (~r_full_d | w_done_d);
    assign w_pend_i = r_full_i | w_cap_i;
    assign w_pend_d = r_full_d | w_cap_d;

    // Owner/other view of the busy port
    assign w_own_d    = w_busy_d;
    assign w_refill   = w_own_d ? w_cap_d  : w_cap_i;
    assign w_oth_pend = w_own_d ? w_pend_i : w_pend_d;

    // IDLE grant: the port not served last wins a tie
    assign w_grant_d = (w_pend_i & w_pend_d) ? ~r_rr : w_pend_d;

    // Request slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full_i <= 1'b0;
            r_full_d <= 1'b0;
            r_slot_i <= '0;
            r_slot_d <= '0;
        end else begin
            r_full_i <= w_cap_i | (r_full_i & ~w_done_i);
            r_full_d <= w_cap_d | (r_full_d & ~w_done_d);
            if (w_cap_i) r_slot_i <= bus.ireq_in;
            if (w_cap_d) r_slot_d <= bus.dreq_in;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_beats <= '0;
            r_rr    <= ~prio_first;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats;
        w_rr_nxt    = r_rr;
        case (r_state)
            IDLE: begin
                if (w_pend_i | w_pend_d) begin
                    w_state_nxt = w_grant_d ? BUSY_D : BUSY_I;
                    w_beats_nxt = BEATS_ONE;
                    w_rr_nxt    = w_grant_d;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    if (w_refill && ((r_beats < BEATS_MAX) || !w_oth_pend)) begin
                        // burst continues without a bubble; count saturates
                        if (r_beats < BEATS_MAX) w_beats_nxt = r_beats + BEATS_ONE;
                    end else if (w_oth_pend) begin
                        w_state_nxt = w_own_d ? BUSY_I : BUSY_D;
                        w_beats_nxt = BEATS_ONE;
                        w_rr_nxt    = ~w_own_d;
                    end else begin
                        w_state_nxt = IDLE;
                        w_beats_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beats_nxt = '0;
            end
        endcase
    end

    // Memory request comes from the owning slot; zero when idle
    always_comb begin
        w_mem_in = '0;
        if (w_busy_i) begin
            w_mem_in           = r_slot_i;
            w_mem_in.mem_valid = 1'b1;
            w_mem_in.mem_instr = 1'b1;
        end else if (w_busy_d) begin
            w_mem_in           = r_slot_d;
            w_mem_in.mem_valid = 1'b1;
            w_mem_in.mem_instr = 1'b0;
        end
    end

    // Responses routed to the owner only, same cycle as memory ready
    always_comb begin
        w_iout = '0;
        w_dout = '0;
        if (w_done_i) w_iout = bus.mem_out;
        if (w_done_d) w_dout = bus.mem_out;
    end

    assign bus.mem_in   = w_mem_in;
    assign bus.ireq_out = w_iout;
    assign bus.dreq_out = w_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (burst_max 4 and 2) driven by
// independent requester models; directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus4 ();
    mem_arbiter_if bus2 ();

    mem_in_type  ireq_in [2];
    mem_in_type  dreq_in [2];
    mem_out_type mem_out_d;
    mem_in_type  mem_in_o [2];
    mem_out_type iout [2];
    mem_out_type dout [2];

    assign bus4.ireq_in = ireq_in[0];
    assign bus4.dreq_in = dreq_in[0];
    assign bus4.mem_out = mem_out_d;
    assign bus2.ireq_in = ireq_in[1];
    assign bus2.dreq_in = dreq_in[1];
    assign bus2.mem_out = mem_out_d;
    assign mem_in_o[0]  = bus4.mem_in;
    assign iout[0]      = bus4.ireq_out;
    assign dout[0]      = bus4.dreq_out;
    assign mem_in_o[1]  = bus2.mem_in;
    assign iout[1]      = bus2.ireq_out;
    assign dout[1]      = bus2.dreq_out;

    mem_arbiter #(.burst_max(4), .prio_first(1'b0)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mem_arbiter #(.burst_max(2), .prio_first(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // requester work lists (port 0=instr, 1=data), shared by both instances
    mem_in_type lst [2][128];
    int         lst_len [2];
    int         head [2][2];
    bit         outst [2][2];

    // completed-beat log per instance
    int          n_log [2];
    int          log_port [2][64];
    logic [31:0] log_addr [2][64];
    logic [31:0] log_rdata [2][64];
    int          log_cyc [2][64];

    // reference model per instance
    int          bmax [2] = '{4, 2};
    int          m_own [2];          // -1 none, 0 instr, 1 data
    int          m_rr [2];
    int          m_beats [2];
    bit          m_full [2][2];
    mem_in_type  m_slot [2][2];

    function automatic mem_in_type mk(input logic [31:0] addr);
        mem_in_type r;
        r           = '0;
        r.mem_addr  = addr;
        r.mem_wdata = addr ^ 32'h5A5A_0000;
        r.mem_wstrb = 4'hF;
        return r;
    endfunction

    function automatic mem_in_type exp_req(input logic [31:0] addr, input bit instr);
        mem_in_type r;
        r           = mk(addr);
        r.mem_valid = 1'b1;
        r.mem_instr = instr;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]   = -1;
            m_rr[k]    = 1;
            m_beats[k] = 0;
            for (int p = 0; p < 2; p++) begin
                m_full[k][p] = 1'b0;
                m_slot[k][p] = '0;
            end
        end
    endtask

    // Applies the arbitration rules to the inputs present at this clock edge
    task automatic model_update();
        mem_in_type req [2];
        bit done, cap [2], pend [2];
        int g, p, q, own_old;
        for (int k = 0; k < 2; k++) begin
            req[0]  = ireq_in[k];
            req[1]  = dreq_in[k];
            own_old = m_own[k];
            done    = mem_out_d.mem_ready && (own_old >= 0);
            for (int j = 0; j < 2; j++) begin
                cap[j]  = req[j].mem_valid && (!m_full[k][j] || (done && own_old == j));
                pend[j] = m_full[k][j] || cap[j];
            end
            if (own_old < 0) begin
                g = -1;
                if (pend[0] && pend[1]) g = 1 - m_rr[k];
                else if (pend[0])       g = 0;
                else if (pend[1])       g = 1;
                if (g >= 0) begin
                    m_own[k] = g; m_beats[k] = 1; m_rr[k] = g;
                end
            end else if (done) begin
                p = own_old;
                q = 1 - p;
                if (cap[p] && (m_beats[k] < bmax[k] || !pend[q])) begin
                    if (m_beats[k] < bmax[k]) m_beats[k]++;
                end else if (pend[q]) begin
                    m_own[k] = q; m_beats[k] = 1; m_rr[k] = q;
                end else if (cap[p]) begin
                    m_beats[k] = 1;
                end else begin
                    m_own[k] = -1; m_beats[k] = 0;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (cap[j]) begin
                    m_full[k][j] = 1'b1;
                    m_slot[k][j] = req[j];
                end else if (done && own_old == j) begin
                    m_full[k][j] = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_tb();
        mem_out_d = '0;
        for (int k = 0; k < 2; k++) begin
            ireq_in[k] = '0;
            dreq_in[k] = '0;
            n_log[k]   = 0;
            for (int p = 0; p < 2; p++) begin
                head[k][p]  = 0;
                outst[k][p] = 1'b0;
            end
        end
        lst_len[0] = 0;
        lst_len[1] = 0;
        model_reset();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_tb();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    // One cycle of stimulus: memory response, then requester reactions to it
    task automatic cycle(input bit rdy, input logic [31:0] rd, input bit g_i, input bit g_d, input bit junk);
        bit r, issue, gate;
        mem_in_type req;
        mem_out_d.mem_ready = rdy;
        mem_out_d.mem_rdata = rd;
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                r     = (p == 0) ? iout[k].mem_ready : dout[k].mem_ready;
                gate  = (p == 0) ? g_i : g_d;
                issue = gate && (head[k][p] < lst_len[p]) && (!outst[k][p] || r);
                req   = '0;
                if (issue) begin
                    req           = lst[p][head[k][p]];
                    req.mem_valid = 1'b1;
                    head[k][p]++;
                    outst[k][p]   = 1'b1;
                end else begin
                    if (r) outst[k][p] = 1'b0;
                    // illegal request while the slot is busy; must be dropped
                    if (junk && outst[k][p]) begin
                        req           = mk($urandom);
                        req.mem_valid = 1'b1;
                    end
                end
                if (p == 0) ireq_in[k] = req;
                else        dreq_in[k] = req;
                if (r && n_log[k] < 64) begin
                    log_port[k][n_log[k]]  = p;
                    log_addr[k][n_log[k]]  = mem_in_o[k].mem_addr;
                    log_rdata[k][n_log[k]] = (p == 0) ? iout[k].mem_rdata : dout[k].mem_rdata;
                    log_cyc[k][n_log[k]]   = cyc;
                    n_log[k]++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_tb();
        mem_out_d = '{mem_ready: 1'b1, mem_rdata: 32'hFFFF_FFFF};
        #2;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k] !== '0) begin
                n_fail++; $display("FAIL reset_mem_in dut%0d got %h want 0", k, mem_in_o[k]);
            end
            n_checks++;
            if (iout[k] !== '0 || dout[k] !== '0) begin
                n_fail++; $display("FAIL reset_ports dut%0d got i=%h d=%h want 0", k, iout[k], dout[k]);
            end
        end
        do_reset();
    endtask

    task automatic test_data_read();
        do_reset();
        lst[1][0] = mk(32'h0000_0100); lst_len[1] = 1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k].mem_valid !== 1'b0) begin
                n_fail++; $display("FAIL read_pre_valid dut%0d got %b want 0", k, mem_in_o[k].mem_valid);
            end
        end
        tick();
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k] !== exp_req(32'h100, 1'b0)) begin
                n_fail++; $display("FAIL read_mem_in dut%0d got %h want %h", k, mem_in_o[k], exp_req(32'h100, 1'b0));
            end
            n_checks++;
            if (dout[k] !== '{mem_ready: 1'b1, mem_rdata: 32'hDEAD_BEEF} || iout[k] !== '0) begin
                n_fail++; $display("FAIL read_resp dut%0d got d=%h i=%h want d=1deadbeef i=0", k, dout[k], iout[k]);
            end
        end
        tick();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k].mem_valid !== 1'b0) begin
                n_fail++; $display("FAIL read_post_idle dut%0d got %b want 0", k, mem_in_o[k].mem_valid);
            end
        end
        tick();
    endtask

    task automatic test_tie_priority();
        do_reset();
        lst[0][0] = mk(32'h200); lst_len[0] = 1;
        lst[1][0] = mk(32'h300); lst_len[1] = 1;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 32'hA000_0000 + 32'(c), 1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (n_log[k] !== 2) begin
                n_fail++; $display("FAIL tie_count dut%0d got %0d want 2", k, n_log[k]);
            end else begin
                n_checks++;
                if (log_port[k][0] !== 0 || log_addr[k][0] !== 32'h200 ||
                    log_port[k][1] !== 1 || log_addr[k][1] !== 32'h300 ||
                    log_cyc[k][1] - log_cyc[k][0] !== 1) begin
                    n_fail++;
                    $display("FAIL tie_order dut%0d got p%0d:%h@%0d p%0d:%h@%0d want p0:200 then p1:300 next cycle",
                             k, log_port[k][0], log_addr[k][0], log_cyc[k][0], log_port[k][1], log_addr[k][1], log_cyc[k][1]);
                end
            end
        end
    endtask

    task automatic test_burst();
        int          ep [2][5];
        logic [31:0] ea [2][5];
        ep = '{'{1, 1, 1, 1, 0}, '{1, 1, 0, 1, 1}};
        ea = '{'{32'h400, 32'h404, 32'h408, 32'h40C, 32'h80},
               '{32'h400, 32'h404, 32'h80, 32'h408, 32'h40C}};
        do_reset();
        for (int i = 0; i < 4; i++) lst[1][i] = mk(32'h400 + 32'(4 * i));
        lst_len[1] = 4;
        lst[0][0]  = mk(32'h80);
        lst_len[0] = 1;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 32'hC000_0000 + 32'(cyc), c != 0, 1'b1, 1'b0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (n_log[k] !== 5 || log_cyc[k][4] - log_cyc[k][0] !== 4) begin
                n_fail++; $display("FAIL burst_count dut%0d got %0d beats over %0d cycles want 5 contiguous",
                                   k, n_log[k], log_cyc[k][4] - log_cyc[k][0] + 1);
            end else begin
                for (int i = 0; i < 5; i++) begin
                    n_checks++;
                    if (log_port[k][i] !== ep[k][i] || log_addr[k][i] !== ea[k][i] ||
                        log_rdata[k][i] !== 32'hC000_0000 + 32'(log_cyc[k][i])) begin
                        n_fail++;
                        $display("FAIL burst_beat%0d dut%0d got p%0d:%h rdata %h want p%0d:%h rdata %h", i, k,
                                 log_port[k][i], log_addr[k][i], log_rdata[k][i], ep[k][i], ea[k][i],
                                 32'hC000_0000 + 32'(log_cyc[k][i]));
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        lst[1][0] = mk(32'h500); lst_len[1] = 1;
        lst[0][0] = mk(32'h600); lst_len[0] = 1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, $urandom, 1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mem_in_o[k] !== exp_req(32'h500, 1'b0) || iout[k] !== '0 || dout[k] !== '0) begin
                    n_fail++; $display("FAIL stall_c%0d dut%0d got mem_in=%h i=%h d=%h want mem_in=%h no ready",
                                       c, k, mem_in_o[k], iout[k], dout[k], exp_req(32'h500, 1'b0));
                end
            end
            tick();
        end
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dout[k] !== '{mem_ready: 1'b1, mem_rdata: 32'h1234_5678} || iout[k] !== '0) begin
                n_fail++; $display("FAIL stall_release dut%0d got d=%h i=%h want d=112345678 i=0", k, dout[k], iout[k]);
            end
        end
        tick();
        cycle(1'b1, 32'h8765_4321, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k] !== exp_req(32'h600, 1'b1) ||
                iout[k] !== '{mem_ready: 1'b1, mem_rdata: 32'h8765_4321}) begin
                n_fail++; $display("FAIL stall_waiter dut%0d got mem_in=%h i=%h want mem_in=%h i=187654321",
                                   k, mem_in_o[k], iout[k], exp_req(32'h600, 1'b1));
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        lst[1][0] = mk(32'h700); lst_len[1] = 1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        mem_out_d = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k].mem_valid !== 1'b1) begin
                n_fail++; $display("FAIL areset_pre dut%0d got valid %b want 1", k, mem_in_o[k].mem_valid);
            end
        end
        mem_out_d = '{mem_ready: 1'b1, mem_rdata: 32'hFFFF_FFFF};
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mem_in_o[k] !== '0 || iout[k] !== '0 || dout[k] !== '0) begin
                n_fail++; $display("FAIL areset_now dut%0d got mem_in=%h i=%h d=%h want all 0",
                                   k, mem_in_o[k], iout[k], dout[k]);
            end
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mem_in_o[k] !== '0 || iout[k] !== '0 || dout[k] !== '0) begin
                    n_fail++; $display("FAIL areset_after_c%0d dut%0d got mem_in=%h i=%h d=%h want all 0",
                                       c, k, mem_in_o[k], iout[k], dout[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit          rdy;
        logic [31:0] rd;
        mem_in_type  em;
        mem_out_type ei, ed;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 128; i++) begin
                lst[p][i]           = mk($urandom);
                lst[p][i].mem_wdata = $urandom;
                lst[p][i].mem_wstrb = 4'($urandom_range(0, 15));
                lst[p][i].mem_fence = 1'($urandom_range(0, 1));
            end
            lst_len[p] = 128;
        end
        for (int c = 0; c < 300; c++) begin
            rdy = ($urandom_range(0, 99) < 60);
            rd  = $urandom;
            cycle(rdy, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            for (int k = 0; k < 2; k++) begin
                em = '0;
                ei = '0;
                ed = '0;
                if (m_own[k] >= 0) begin
                    em           = m_slot[k][m_own[k]];
                    em.mem_valid = 1'b1;
                    em.mem_instr = (m_own[k] == 0);
                end
                if (rdy && m_own[k] == 0) ei = '{mem_ready: 1'b1, mem_rdata: rd};
                if (rdy && m_own[k] == 1) ed = '{mem_ready: 1'b1, mem_rdata: rd};
                n_checks++;
                if (mem_in_o[k] !== em) begin
                    n_fail++; $display("FAIL rand_mem_in c%0d dut%0d got %h want %h", c, k, mem_in_o[k], em);
                end
                n_checks++;
                if (iout[k] !== ei) begin
                    n_fail++; $display("FAIL rand_iout c%0d dut%0d got %h want %h", c, k, iout[k], ei);
                end
                n_checks++;
                if (dout[k] !== ed) begin
                    n_fail++; $display("FAIL rand_dout c%0d dut%0d got %h want %h", c, k, dout[k], ed);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_tie_priority();
        test_burst();
        test_stall();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
